alu_shift_seq: RTL and testbench
================================

Name: alu_shift_seq

Overview:
Iterative shift unit directly upstream of the ALU result multiplexer. It computes the logical-left (LLS) and arithmetic-right (ASR) results over several clock cycles, trading latency for area in place of a 32-bit barrel shifter. Both results are registered and presented on dedicated ports that drive the multiplexer's LLS and ASR inputs. A START/BUSY/DONE handshake connects it to the control FSM.

Parameters:
STEP, 1, bits shifted per cycle; legal values 1, 2, 4, 8, 16, 32. Other values are a configuration error.

Ports:
CLK  input  1  system clock, rising-edge
RST  input  1  synchronous reset, active-high
START  input  1  request a new shift; sampled only in IDLE
OP  input  1  0 = logical left (LLS), 1 = arithmetic right (ASR)
A  input  32  operand to shift
SHAMT  input  5  shift amount, 0..31
BUSY  output  1  high whenever state is not IDLE
DONE  output  1  one-cycle pulse; the result for the op just finished is valid
LLS  output  32  last completed left-shift result, held between ops
ASR  output  32  last completed arithmetic-right result, held between ops

Behaviour:
- Clock and reset: single clock, CLK. RST is synchronous and active-high, sampled on the rising edge of CLK.
- Reset: state=IDLE, BUSY=0, DONE=0, LLS=0, ASR=0, working register=0, remaining count=0.
- RST high mid-operation aborts the operation. No DONE is produced. Outputs return to their reset values.
- States: IDLE, SHIFT, FIN.
- IDLE:
  - If START=1 at an edge, latch A into the working register W, SHAMT into the remaining count R, and OP.
  - Next state is SHIFT if SHAMT!=0, otherwise FIN.
  - If START=0, stay in IDLE.
- SHIFT, on each edge:
  - Shift amount s = min(STEP, R).
  - OP=0: W <= W << s, zero fill.
  - OP=1: W <= W >>> s, filling with W[31].
  - R <= R - s.
  - If R <= STEP, go to FIN; else stay in SHIFT.
- Entering FIN writes the final W into LLS (OP=0) or ASR (OP=1). The other output register is untouched.
- FIN lasts exactly one cycle:
  - DONE=1 for that cycle.
  - Next state is IDLE unconditionally.
- BUSY=1 in SHIFT and FIN.
- START while BUSY=1 is ignored, not queued. START in the FIN cycle is also ignored.
- The first START is accepted in the cycle after DONE. Back-to-back ops therefore cost one idle cycle.
- Latency: START is sampled high in cycle 0; N = ceil(SHAMT/STEP); DONE is high in cycle N+1.
  - SHAMT=0 gives DONE in cycle 1, with result = A.
- Operand changes: A, SHAMT and OP may change freely after acceptance. Only the latched copies are used.
- LLS and ASR change only on the edge entering FIN, or on reset. They are stable otherwise, so the downstream mux sees glitch-free values.
- Width rules:
  - All shifts are on 32 bits. Bits shifted out are discarded.
  - SHAMT=31 with OP=1 yields all copies of A[31].

Test Plan:
1. RST held 2 cycles, then released -> BUSY=0, DONE=0, LLS=0, ASR=0.
2. STEP=1, OP=0, A=32'h0000_0001, SHAMT=5, START pulse in cycle 0 -> BUSY=1 in cycles 1-6; DONE=1 only in cycle 6; LLS=32'h0000_0020; ASR unchanged at 0.
3. STEP=4, OP=1, A=32'h8000_00F0, SHAMT=7 -> DONE in cycle 3 (N=2); ASR=32'hFF00_0001; LLS unchanged.
4. STEP=4, OP=1, A=32'h7FFF_FFFF, SHAMT=31 -> DONE in cycle 9; ASR=32'h0000_0000. Repeat with A=32'h8000_0000 -> ASR=32'hFFFF_FFFF.
5. SHAMT=0, OP=0, A=32'hDEAD_BEEF -> DONE in cycle 1; LLS=32'hDEAD_BEEF. A second START held high through BUSY with A=1, SHAMT=1 -> ignored until the cycle after DONE, then accepted; LLS becomes 32'h0000_0002.
6. STEP=1, SHAMT=20, RST asserted in cycle 10 -> no DONE pulse; BUSY=0, LLS=0, ASR=0 from cycle 11; a fresh START is then accepted normally.

Source files
------------

// File: rtl/alu_shift_seq.sv
// rtl/alu_shift_seq.sv - iterative LLS/ASR shift unit with START/BUSY/DONE handshake
module alu_shift_seq #(
    parameter int STEP = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        OP,
    input  logic [31:0] A,
    input  logic [4:0]  SHAMT,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] LLS,
    output logic [31:0] ASR
);

    localparam logic [5:0] STEP_W = 6'(STEP);

    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

    state_t      state;
    logic [31:0] w;
    logic [4:0]  r;
    logic        op_q;

    logic [4:0]  s;
    logic [31:0] w_next;
    logic        last;

    // STEP=32 truncates to 0 in five bits, but r never reaches 32 so s=r then
    always_comb begin
        s      = ({1'b0, r} < STEP_W) ? r : STEP_W[4:0];
        w_next = op_q ? $unsigned($signed(w) >>> s) : (w << s);
        last   = ({1'b0, r} <= STEP_W);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            LLS   <= '0;
            ASR   <= '0;
            w     <= '0;
            r     <= '0;
            op_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        w    <= A;
                        r    <= SHAMT;
                        op_q <= OP;
                        BUSY <= 1'b1;
                        if (SHAMT != 5'd0) begin
                            state <= SHIFT;
                        end else begin
                            // zero shift goes straight to FIN with the operand as result
                            state <= FIN;
                            DONE  <= 1'b1;
                            if (OP) ASR <= A;
                            else    LLS <= A;
                        end
                    end
                end
                SHIFT: begin
                    w <= w_next;
                    r <= r - s;
                    if (last) begin
                        state <= FIN;
                        DONE  <= 1'b1;
                        if (op_q) ASR <= w_next;
                        else      LLS <= w_next;
                    end
                end
                FIN: begin
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    DONE  <= 1'b0;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_shift_seq.sv
// tb/tb_alu_shift_seq.sv - directed self-checking bench for alu_shift_seq (STEP=1 and STEP=4)
module tb_alu_shift_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, start4;
    logic        op;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        busy1, done1, busy4, done4;
    logic [31:0] lls1, asr1, lls4, asr4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_shift_seq #(.STEP(1)) u1 (
        .CLK(clk), .RST(rst), .START(start1), .OP(op), .A(a), .SHAMT(shamt),
        .BUSY(busy1), .DONE(done1), .LLS(lls1), .ASR(asr1)
    );

    alu_shift_seq #(.STEP(4)) u4 (
        .CLK(clk), .RST(rst), .START(start4), .OP(op), .A(a), .SHAMT(shamt),
        .BUSY(busy4), .DONE(done4), .LLS(lls4), .ASR(asr4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance one edge; sample 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // launch one op on the selected instance, watch a 40-cycle window
    task automatic run_op(input int sel, input logic o, input logic [31:0] av,
                          input logic [4:0] sh, output int done_cyc,
                          output int done_cnt, output int busy_cnt);
        op = o; a = av; shamt = sh;
        if (sel == 4) start4 = 1'b1; else start1 = 1'b1;
        done_cyc = -1; done_cnt = 0; busy_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            start1 = 1'b0; start4 = 1'b0;
            a = 32'h5A5A_A5A5; shamt = 5'd13; op = ~o;
            if ((sel == 4) ? done4 : done1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if ((sel == 4) ? busy4 : busy1) busy_cnt++;
        end
    endtask

    int dc, dn, bc;
    int seen_done;

    initial begin
        rst = 1'b1; start1 = 1'b0; start4 = 1'b0; op = 1'b0; a = '0; shamt = '0;

        // 1: reset
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_busy", {30'd0, busy1, busy4}, 32'd0);
        check("rst_done", {30'd0, done1, done4}, 32'd0);
        check("rst_lls", lls1 | lls4, 32'd0);
        check("rst_asr", asr1 | asr4, 32'd0);

        // 2: STEP=1 LLS 1<<5
        run_op(1, 1'b0, 32'h0000_0001, 5'd5, dc, dn, bc);
        check("t2_done_cyc", dc, 32'd6);
        check("t2_done_cnt", dn, 32'd1);
        check("t2_busy_cnt", bc, 32'd6);
        check("t2_lls", lls1, 32'h0000_0020);
        check("t2_asr", asr1, 32'h0000_0000);

        // 3: STEP=4 ASR, N=2
        run_op(4, 1'b1, 32'h8000_00F0, 5'd7, dc, dn, bc);
        check("t3_done_cyc", dc, 32'd3);
        check("t3_busy_cnt", bc, 32'd3);
        check("t3_asr", asr4, 32'hFF00_0001);
        check("t3_lls", lls4, 32'h0000_0000);

        // 4: STEP=4 ASR by 31, both signs
        run_op(4, 1'b1, 32'h7FFF_FFFF, 5'd31, dc, dn, bc);
        check("t4a_done_cyc", dc, 32'd9);
        check("t4a_asr", asr4, 32'h0000_0000);
        run_op(4, 1'b1, 32'h8000_0000, 5'd31, dc, dn, bc);
        check("t4b_done_cyc", dc, 32'd9);
        check("t4b_asr", asr4, 32'hFFFF_FFFF);
        check("t4b_lls", lls4, 32'h0000_0000);

        // 4c: STEP=4 LLS with SHAMT a multiple of STEP
        run_op(4, 1'b0, 32'h0000_00AB, 5'd8, dc, dn, bc);
        check("t4c_done_cyc", dc, 32'd3);
        check("t4c_lls", lls4, 32'h0000_AB00);
        check("t4c_asr", asr4, 32'hFFFF_FFFF);

        // 5: zero shift, then START held high through FIN
        op = 1'b0; a = 32'hDEAD_BEEF; shamt = 5'd0; start1 = 1'b1;
        tick();
        check("t5_done_c1", {31'd0, done1}, 32'd1);
        check("t5_lls_c1", lls1, 32'hDEAD_BEEF);
        a = 32'h0000_0001; shamt = 5'd1;
        tick();
        check("t5_busy_c2", {31'd0, busy1}, 32'd0);
        check("t5_done_c2", {31'd0, done1}, 32'd0);
        tick();
        start1 = 1'b0;
        check("t5_busy_c3", {31'd0, busy1}, 32'd1);
        check("t5_lls_c3", lls1, 32'hDEAD_BEEF);
        tick();
        check("t5_done_c4", {31'd0, done1}, 32'd1);
        check("t5_lls_c4", lls1, 32'h0000_0002);
        tick();

        // 6: abort by reset mid-op
        op = 1'b0; a = 32'h0000_0003; shamt = 5'd20; start1 = 1'b1;
        seen_done = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start1 = 1'b0;
            if (done1) seen_done++;
        end
        check("t6_busy_c10", {31'd0, busy1}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if (done1) seen_done++;
        check("t6_no_done", seen_done, 32'd0);
        check("t6_busy_c11", {31'd0, busy1}, 32'd0);
        check("t6_lls_c11", lls1, 32'd0);
        check("t6_asr_c11", asr1, 32'd0);
        run_op(1, 1'b1, 32'h8000_0000, 5'd4, dc, dn, bc);
        check("t6_re_done_cyc", dc, 32'd5);
        check("t6_re_asr", asr1, 32'hF800_0000);
        check("t6_re_lls", lls1, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
